// File: rtl/param_byte_memory.sv
// Byte-addressed little-endian data memory with valid/ready handshake and configurable read latency.
// Define PARAM_BYTE_MEMORY_MISALIGN_TRAP_EN to turn misaligned half/word accesses into error responses.
module param_byte_memory #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int                DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [3:0]        LAT_INIT  = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_count;
    logic [7:0]            r_mem [DEPTH];
    logic [31:0]           r_rdata;
    logic                  r_error;

    logic                  w_accept;
    logic [1:0]            w_span;
    logic [3:0]            w_lane;
    logic                  w_size_bad;
    logic                  w_high_nz;
    logic                  w_over;
    logic                  w_misalign;
    logic                  w_error;
    logic [ADDR_WIDTH-1:0] w_idx [4];
    logic [31:0]           w_raw;
    logic [31:0]           w_load_data;
    logic [31:0]           w_rsp_data;

    assign req_ready = (r_state == IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_error = r_error;

    // w_span is the offset of the last byte touched; w_lane marks the active byte lanes.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_span = 2'd0;
        w_lane = 4'b0000;
        case (req_size)
            2'b00:   begin w_span = 2'd0; w_lane = 4'b0001; end
            2'b01:   begin w_span = 2'd1; w_lane = 4'b0011; end
            2'b10:   begin w_span = 2'd3; w_lane = 4'b1111; end
            default: begin w_span = 2'd0; w_lane = 4'b0000; end
        endcase
    end

    assign w_size_bad = (req_size == 2'b11);
    assign w_high_nz  = |(req_addr >> ADDR_WIDTH);
    assign w_over     = ({1'b0, req_addr[ADDR_WIDTH-1:0]} + (ADDR_WIDTH + 1)'(w_span)) > LAST_ADDR;

`ifdef PARAM_BYTE_MEMORY_MISALIGN_TRAP_EN
    assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_error = w_size_bad || w_high_nz || w_over || w_misalign;

    always_comb begin
        w_raw = '0;
        for (int k = 0; k < 4; k++) begin
            w_idx[k] = req_addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k);
            if (w_lane[k]) begin
                w_raw[8*k +: 8] = r_mem[w_idx[k]];
            end
        end
    end

    always_comb begin
        w_load_data = w_raw;
        case (req_size)
            2'b00:   w_load_data = {{24{!req_unsigned && w_raw[7]}}, w_raw[7:0]};
            2'b01:   w_load_data = {{16{!req_unsigned && w_raw[15]}}, w_raw[15:0]};
            default: w_load_data = w_raw;
        endcase
    end

    assign w_rsp_data = (req_write || w_error) ? 32'h0 : w_load_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (req_write || READ_LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (r_count == 4'd1) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 4'd0;
            r_rdata <= 32'h0;
            r_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_count <= req_write ? 4'd0 : LAT_INIT;
                r_rdata <= w_rsp_data;
                r_error <= w_error;
            end else if (r_state == BUSY) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    // Load data is captured at the accept edge, so later stores never disturb an in-flight load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: storage is flop-based and cleared on reset because contents must read 0 afterwards.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_accept && req_write && !w_error) begin
            for (int k = 0; k < 4; k++) begin
                if (w_lane[k]) begin
                    r_mem[w_idx[k]] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_param_byte_memory.sv
// Scoreboard bench for param_byte_memory (ADDR_WIDTH=10, READ_LATENCY=3); the driver queues
// expectations and a negedge monitor checks data, error, latency and hold stability.
module tb_param_byte_memory;

    localparam int AW = 10;
    localparam int RL = 3;

`ifdef PARAM_BYTE_MEMORY_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   age      = 0;
    bit   in_flight = 1'b0;
    bit   seen      = 1'b0;

    param_byte_memory #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: inputs change at posedge+1, so at a negedge they show what the next edge samples.
    always @(negedge clk) begin
        if (reset) begin
            in_flight = 1'b0;
            seen      = 1'b0;
        end else begin
            if (in_flight) age++;
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_rsp_valid", {31'b0, rsp_valid}, 32'd0);
                end else begin
                    if (!seen) begin
                        check($sformatf("%s_latency", q[0].name), age, q[0].lat);
                        check($sformatf("%s_rdata", q[0].name), rsp_rdata, q[0].rdata);
                        check($sformatf("%s_error", q[0].name), {31'b0, rsp_error}, {31'b0, q[0].err});
                        seen = 1'b1;
                    end else begin
                        check($sformatf("%s_held_rdata", q[0].name), rsp_rdata, q[0].rdata);
                        check($sformatf("%s_held_req_ready", q[0].name), {31'b0, req_ready}, 32'd0);
                    end
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        in_flight = 1'b0;
                        seen      = 1'b0;
                    end
                end
            end else if (in_flight && age > 32) begin
                check("rsp_never_arrived", {31'b0, rsp_valid}, 32'd1);
                if (q.size() != 0) void'(q.pop_front());
                in_flight = 1'b0;
            end
            if (req_valid && req_ready) begin
                in_flight = 1'b1;
                age       = 0;
                seen      = 1'b0;
            end
        end
    end

    task automatic txn(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e, input int hold);
        exp_t e;
        for (int i = 0; i < 20 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        e.name  = name;
        e.rdata = exp_d;
        e.err   = exp_e;
        e.lat   = wr ? 1 : RL;
        q.push_back(e);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        if (!rsp_valid) check({name, "_rsp_timeout"}, {31'b0, rsp_valid}, 32'd1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        rsp_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", {31'b0, req_ready}, 32'd0);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_error", {31'b0, rsp_error}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_req_ready", {31'b0, req_ready}, 32'd1);

        txn("sw4",   1'b1, 2'b10, 1'b0, 32'd4,  32'h0000_00C8, 32'h0, 1'b0, 0);
        txn("lw4",   1'b0, 2'b10, 1'b0, 32'd4,  32'h0,         32'h0000_00C8, 1'b0, 0);
        txn("sw8",   1'b1, 2'b10, 1'b0, 32'd8,  32'h80FF_7F01, 32'h0, 1'b0, 0);
        txn("lb10",  1'b0, 2'b00, 1'b0, 32'd10, 32'h0,         32'hFFFF_FFFF, 1'b0, 0);
        txn("lbu10", 1'b0, 2'b00, 1'b1, 32'd10, 32'h0,         32'h0000_00FF, 1'b0, 0);
        txn("lh10",  1'b0, 2'b01, 1'b0, 32'd10, 32'h0,         32'hFFFF_80FF, 1'b0, 0);
        txn("lhu10", 1'b0, 2'b01, 1'b1, 32'd10, 32'h0,         32'h0000_80FF, 1'b0, 0);
        txn("lb9",   1'b0, 2'b00, 1'b0, 32'd9,  32'h0,         32'h0000_007F, 1'b0, 0);
        txn("sb9",   1'b1, 2'b00, 1'b0, 32'd9,  32'h1234_56AB, 32'h0, 1'b0, 0);
        txn("lw8",   1'b0, 2'b10, 1'b0, 32'd8,  32'h0,         32'h80FF_AB01, 1'b0, 0);

        txn("sw30",  1'b1, 2'b10, 1'b0, 32'd30, 32'hFFFF_FFFE, 32'h0, TRAP, 0);
        txn("lbu30", 1'b0, 2'b00, 1'b1, 32'd30, 32'h0, TRAP ? 32'h0 : 32'h0000_00FE, 1'b0, 0);
        txn("lbu33", 1'b0, 2'b00, 1'b1, 32'd33, 32'h0, TRAP ? 32'h0 : 32'h0000_00FF, 1'b0, 0);
        txn("lw30",  1'b0, 2'b10, 1'b0, 32'd30, 32'h0, TRAP ? 32'h0 : 32'hFFFF_FFFE, TRAP, 0);
        txn("lh31",  1'b0, 2'b01, 1'b0, 32'd31, 32'h0, TRAP ? 32'h0 : 32'hFFFF_FFFF, TRAP, 0);

        txn("lw3fe",  1'b0, 2'b10, 1'b0, 32'h3FE, 32'h0, 32'h0, 1'b1, 0);
        txn("sb400",  1'b1, 2'b00, 1'b0, 32'h400, 32'h0000_0055, 32'h0, 1'b1, 0);
        txn("lbu0",   1'b0, 2'b00, 1'b1, 32'h000, 32'h0, 32'h0, 1'b0, 0);
        txn("lbu3ff", 1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0, 32'h0, 1'b0, 0);
        txn("sb3ff",  1'b1, 2'b00, 1'b0, 32'h3FF, 32'h0000_005A, 32'h0, 1'b0, 0);
        txn("lb3ff",  1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, 32'h0000_005A, 1'b0, 0);
        txn("lh3ff",  1'b0, 2'b01, 1'b0, 32'h3FF, 32'h0, 32'h0, 1'b1, 0);
        txn("lbu_hi", 1'b0, 2'b00, 1'b1, 32'h8000_0004, 32'h0, 32'h0, 1'b1, 0);
        txn("lsz11",  1'b0, 2'b11, 1'b0, 32'd4, 32'h0, 32'h0, 1'b1, 0);
        txn("ssz11",  1'b1, 2'b11, 1'b0, 32'd4, 32'h1111_1111, 32'h0, 1'b1, 0);
        txn("lw4_hold", 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'h0000_00C8, 1'b0, 2);

        // Reset pulsed while a load sits in BUSY.
        txn("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678, 32'h0, 1'b0, 0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h20;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        q.delete();
        #1;
        check("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midreset_req_ready", {31'b0, req_ready}, 32'd0);
        check("midreset_rsp_rdata", rsp_rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("postreset_rsp_valid_%0d", i), {31'b0, rsp_valid}, 32'd0);
        end
        txn("lw20_cleared", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 0);
        txn("lw4_cleared",  1'b0, 2'b10, 1'b0, 32'd4,  32'h0, 32'h0, 1'b0, 0);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_byte_memory.md
Name: param_byte_memory

Overview:
- Byte-addressed, little-endian data memory with a parametrised depth and a parametrised read latency.
- Supports byte, half and word accesses, with sign or zero extension on loads.
- Uses a valid/ready request–response handshake, one transaction outstanding at a time.
- Sits between the multicycle datapath's load/store control and storage; replaces the fixed 32-bit memRead/memWrite memory.

Parameters:
- ADDR_WIDTH, 10, byte-address bits actually decoded; depth is 2**ADDR_WIDTH bytes.
- READ_LATENCY, 1, cycles from request accept to rsp_valid for reads; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low bytes are used per req_size.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_error  output  1  illegal size, out-of-range or trapped misaligned access.

Behaviour:
- Reset (async): state returns to IDLE, req_ready=0 while reset is high, rsp_valid=0, rsp_rdata=0, rsp_error=0, latency counter=0. All memory bytes are cleared to 0x00.
- FSM states and transitions:
  - IDLE: req_ready=1. Accept when req_valid&&req_ready. Store → RESP. Load with READ_LATENCY=1 → RESP. Load otherwise → BUSY, counter=READ_LATENCY-1.
  - BUSY: req_ready=0. Counter decrements each cycle; at 1 → RESP.
  - RESP: rsp_valid=1; rsp_rdata and rsp_error are held stable. On rsp_ready → IDLE, rsp_valid falls on the next edge. Back-to-back accept is not allowed; one IDLE cycle sits between transactions.
- Store: the bytes at addr..addr+N-1 (N=1/2/4) are written with req_wdata[8N-1:0] little-endian at the accept edge. rsp_valid rises 1 cycle after accept.
- Load:
  - Bytes are sampled at the accept edge, so a later store cannot affect an in-flight load.
  - Data is assembled little-endian, then sign- or zero-extended from bit 8N-1.
  - rsp_valid is asserted exactly READ_LATENCY cycles after the accept edge.
- Range: an access is out of range if any byte address addr+k ≥ 2**ADDR_WIDTH, or any of req_addr[31:ADDR_WIDTH] is nonzero. The response is rsp_error=1, rsp_rdata=0, and no byte is modified. There is no wrap-around.
- req_size=11: rsp_error=1, no access.
- Error responses use the same timing as a legal access of the same direction.
- Reset asserted mid-BUSY or mid-RESP: the pending response is discarded and no rsp_valid appears after reset release. A store already committed is cleared along with all other contents.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro PARAM_BYTE_MEMORY_MISALIGN_TRAP_EN.
- Defined: a half at an odd address, or a word with addr[1:0]≠0, gives rsp_error=1, no write, rsp_rdata=0.
- Undefined: misaligned accesses complete byte-wise across any boundary, subject only to the range check.

Test Plan:
- Word store 0x000000C8 at addr 4, then word load at 4 → rsp_rdata=0x000000C8 (200), rsp_error=0.
- Word store 0x80FF7F01 at 8, then loads:
  - lb 10 → 0xFFFFFFFF
  - lbu 10 → 0x000000FF
  - lh 10 → 0xFFFF80FF
  - lhu 10 → 0x000080FF
  - lb 9 → 0x0000007F
- Byte store 0xAB at 9 after the previous case, then word load at 8 → 0x80FFAB01; bytes 8, 10, 11 are unchanged.
- Word store 0xFFFFFFFE at 30:
  - With trap enabled → rsp_error=1, bytes 30..33 stay 00.
  - Without trap → bytes 30..33 = FE FF FF FF, and a word load at 30 → 0xFFFFFFFE.
- ADDR_WIDTH=10:
  - Word load at 0x3FE → rsp_error=1.
  - Byte store at 0x400 → rsp_error=1, no byte changes.
  - Byte load at 0x3FF → 0x00000000, rsp_error=0.
- READ_LATENCY=3:
  - rsp_valid rises exactly 3 cycles after accept.
  - With rsp_ready held low 2 extra cycles, the data is held stable and req_ready=0 throughout.
  - Reset pulsed during BUSY → rsp_valid stays 0, and a following load of the stored address returns 0.
